fetch_unit: RTL

//  Program-counter/fetch sequencer on the read side of instruction_memory.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Program-counter / fetch sequencer on the read side of instruction_memory.
// Two-phase fetch (address cycle, check cycle), valid/ready handoff to decode, branch redirect and halt.
module fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instruct,
    input  logic               imem_done,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        CHECK = 3'd2,
        HOLD  = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic [INSTR_W-1:0] instr_n;
    logic [ADDR_W-1:0]  instr_pc_n;
    logic               valid_n;
    logic               halted_n;
    logic [CNT_W-1:0]   count_n;
    logic               wrap, wrap_n;
    logic               transfer;

    assign transfer  = instr_valid && instr_ready;
    assign imem_addr = pc;

    always_comb begin
        // NOTE: every next-value defaults to the current register first so no path infers a latch.
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr;
        instr_pc_n = instr_pc;
        valid_n    = instr_valid;
        halted_n   = halted;
        count_n    = fetch_count;
        wrap_n     = wrap;

        case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_n  = ADDR;
                    pc_n     = '0;
                    count_n  = '0;
                    halted_n = 1'b0;
                    wrap_n   = 1'b0;
                end
            end
            ADDR: state_n = CHECK;
            CHECK: begin
                if (imem_done) begin
                    state_n  = HALT;
                    halted_n = 1'b1;
                end else begin
                    instr_n    = imem_instruct;
                    instr_pc_n = pc;
                    valid_n    = 1'b1;
                    pc_n       = pc + ADDR_W'(1);
                    if (&pc) wrap_n = 1'b1;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (transfer) begin
                    valid_n = 1'b0;
                    count_n = fetch_count + CNT_W'(1);
                    if (wrap) begin
                        state_n  = HALT;
                        halted_n = 1'b1;
                    end else begin
                        state_n = ADDR;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Redirect overrides the state rules above but keeps a same-cycle transfer in the count.
        if (branch_taken && (state == ADDR || state == CHECK || state == HOLD)) begin
            state_n    = ADDR;
            pc_n       = branch_target;
            valid_n    = 1'b0;
            wrap_n     = 1'b0;
            halted_n   = 1'b0;
            instr_n    = instr;
            instr_pc_n = instr_pc;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
            wrap        <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= valid_n;
            halted      <= halted_n;
            fetch_count <= count_n;
            wrap        <= wrap_n;
        end
    end

endmodule
